// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it drives.
// State codes, opcode/funct values and every select encoding live here.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ADDI   = 4'd8,
        S_ORI    = 4'd9,
        S_ALUWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_JR     = 2'd3;

    // States that wait on mem_ready and are covered by the watchdog.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit to datapath bundle: decode inputs, memory handshake and all selects/strobes.
interface mc_control_fsm_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] MemToReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, bus_err
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, bus_err
    );
endinterface

// File: rtl/mc_mem_watchdog.sv
// Counts stalled cycles in a memory-wait state and flags a timeout when the limit is reached.
module mc_mem_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_mem,
    input  logic mem_ready,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // mem_ready has priority: a completing access never times out.
    assign timeout = in_mem && !mem_ready && (cnt_reg == LIMIT);

    // Mem states only exit on ready or timeout, so clearing outside them also clears on entry.
    always_comb begin
        cnt_next = '0;
        if (in_mem && !mem_ready && !timeout)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and strobe, with a watchdog on memory waits.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);
    state_t     state_reg, state_next;
    logic [1:0] dst_reg, dst_next;
    logic       in_mem;
    logic       timeout;

    assign in_mem = is_mem_state(state_reg);

    mc_mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_mem   (in_mem),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_RST;
            dst_reg   <= RD_RT;
        end else begin
            state_reg <= state_next;
            dst_reg   <= dst_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        dst_next         = dst_reg;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemToReg     = M2R_ALUOUT;
        bus.RegDst       = RD_RT;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = SRCB_B;
        bus.ALUOp        = ALU_ADD;
        bus.PCSource     = PCS_ALU;
        bus.illegal_op   = 1'b0;
        bus.bus_err      = timeout;

        case (state_reg)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                bus.MemRead = !timeout;
                bus.ALUSrcB = SRCB_4;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM_SH;
                case (bus.Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = (bus.Funct == FN_JR) ? S_JR : S_RTYPE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_JAL:       state_next = S_JAL;
                    OP_ADDI:      state_next = S_ADDI;
                    OP_ORI:       state_next = S_ORI;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = !timeout;
                bus.IorD    = 1'b1;
                if (bus.mem_ready)
                    state_next = S_MEMWB;
                else if (timeout)
                    state_next = S_FETCH;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = M2R_MDR;
                state_next   = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = !timeout;
                bus.IorD     = 1'b1;
                if (bus.mem_ready || timeout)
                    state_next = S_FETCH;
            end
            S_RTYPE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
                dst_next    = RD_RD;
                state_next  = S_ALUWB;
            end
            S_ADDI: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                dst_next    = RD_RT;
                state_next  = S_ALUWB;
            end
            S_ORI: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALU_OR;
                dst_next    = RD_RT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = dst_reg;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCS_ALUOUT;
                state_next      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCS_JUMP;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch, so it is the link value.
                bus.RegWrite = 1'b1;
                bus.MemToReg = M2R_PC;
                bus.RegDst   = RD_RA;
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCS_JUMP;
                state_next   = S_FETCH;
            end
            S_JR: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCS_JR;
                state_next   = S_FETCH;
            end
            default: state_next = S_RST;
        endcase

        // A reset landing mid-instruction must not commit anything in that cycle.
        if (!rst_n) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench: stimulus pushes hand-computed control vectors, a monitor compares each cycle.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mc_control_fsm_if bus ();

    mc_control_fsm #(
        .MEM_TIMEOUT(16),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst
    //               RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal_op bus_err
    function automatic logic [19:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mrd,
        input logic mwr, input logic irw, input logic [1:0] m2r, input logic [1:0] rdst,
        input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic [1:0] pcs, input logic ill, input logic berr);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, berr};
    endfunction

    localparam logic [19:0] E_RST      = 20'd0;
    localparam logic [19:0] E_FETCH_R  = mk(1,0,0,1,0,1,2'd0,2'd0,0,0,2'd1,2'd0,2'd0,0,0);
    localparam logic [19:0] E_FETCH_W  = mk(0,0,0,1,0,0,2'd0,2'd0,0,0,2'd1,2'd0,2'd0,0,0);
    localparam logic [19:0] E_DEC      = mk(0,0,0,0,0,0,2'd0,2'd0,0,0,2'd3,2'd0,2'd0,0,0);
    localparam logic [19:0] E_DEC_ILL  = mk(0,0,0,0,0,0,2'd0,2'd0,0,0,2'd3,2'd0,2'd0,1,0);
    localparam logic [19:0] E_MADR     = mk(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,2'd0,2'd0,0,0);
    localparam logic [19:0] E_MRD      = mk(0,0,1,1,0,0,2'd0,2'd0,0,0,2'd0,2'd0,2'd0,0,0);
    localparam logic [19:0] E_MWB      = mk(0,0,0,0,0,0,2'd1,2'd0,1,0,2'd0,2'd0,2'd0,0,0);
    localparam logic [19:0] E_MWR      = mk(0,0,1,0,1,0,2'd0,2'd0,0,0,2'd0,2'd0,2'd0,0,0);
    localparam logic [19:0] E_MWR_TO   = mk(0,0,1,0,0,0,2'd0,2'd0,0,0,2'd0,2'd0,2'd0,0,1);
    localparam logic [19:0] E_RTYPE    = mk(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,2'd2,2'd0,0,0);
    localparam logic [19:0] E_ADDI     = mk(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,2'd0,2'd0,0,0);
    localparam logic [19:0] E_ORI      = mk(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,2'd3,2'd0,0,0);
    localparam logic [19:0] E_WB_RD    = mk(0,0,0,0,0,0,2'd0,2'd1,1,0,2'd0,2'd0,2'd0,0,0);
    localparam logic [19:0] E_WB_RT    = mk(0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,2'd0,2'd0,0,0);
    localparam logic [19:0] E_BRANCH   = mk(0,1,0,0,0,0,2'd0,2'd0,0,1,2'd0,2'd1,2'd1,0,0);
    localparam logic [19:0] E_JUMP     = mk(1,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,2'd0,2'd2,0,0);
    localparam logic [19:0] E_JAL      = mk(1,0,0,0,0,0,2'd2,2'd2,1,0,2'd0,2'd0,2'd2,0,0);
    localparam logic [19:0] E_JR       = mk(1,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,2'd0,2'd3,0,0);

    typedef struct {
        string       nm;
        logic [19:0] exp;
    } exp_t;

    exp_t q[$];

    logic [19:0] act;
    assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op, bus.bus_err};

    task automatic step(input string nm, input logic rn, input logic [5:0] op,
                        input logic [5:0] fn, input logic rdy, input logic [19:0] e);
        exp_t item;
        rst_n         = rn;
        bus.Op        = op;
        bus.Funct     = fn;
        bus.mem_ready = rdy;
        item.nm       = nm;
        item.exp      = e;
        q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                item = q.pop_front();
                total++;
                if (act !== item.exp) begin
                    bad++;
                    $display("FAIL %s act=%05h req=%05h", item.nm, act, item.exp);
                end else begin
                    $display("txn %s vec=%05h ok", item.nm, act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.Op        = OP_RTYPE;
        bus.Funct     = 6'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step("reset_hold", 0, OP_RTYPE, 6'd0, 1, E_RST);
        step("reset_release", 1, OP_RTYPE, 6'd0, 1, E_RST);

        step("lw_fetch",  1, OP_LW, 6'd0, 1, E_FETCH_R);
        step("lw_decode", 1, OP_LW, 6'd0, 1, E_DEC);
        step("lw_memadr", 1, OP_LW, 6'd0, 1, E_MADR);
        step("lw_memrd",  1, OP_LW, 6'd0, 1, E_MRD);
        step("lw_memwb",  1, OP_LW, 6'd0, 1, E_MWB);

        step("sw_fetch",  1, OP_SW, 6'd0, 1, E_FETCH_R);
        step("sw_decode", 1, OP_SW, 6'd0, 1, E_DEC);
        step("sw_memadr", 1, OP_SW, 6'd0, 1, E_MADR);
        step("sw_memwr",  1, OP_SW, 6'd0, 1, E_MWR);

        step("add_fetch",  1, OP_RTYPE, 6'b100000, 1, E_FETCH_R);
        step("add_decode", 1, OP_RTYPE, 6'b100000, 1, E_DEC);
        step("add_exec",   1, OP_RTYPE, 6'b100000, 1, E_RTYPE);
        step("add_wb",     1, OP_RTYPE, 6'b100000, 1, E_WB_RD);

        step("addi_fetch",  1, OP_ADDI, 6'd0, 1, E_FETCH_R);
        step("addi_decode", 1, OP_ADDI, 6'd0, 1, E_DEC);
        step("addi_exec",   1, OP_ADDI, 6'd0, 1, E_ADDI);
        step("addi_wb",     1, OP_ADDI, 6'd0, 1, E_WB_RT);

        step("ori_fetch",  1, OP_ORI, 6'd0, 1, E_FETCH_R);
        step("ori_decode", 1, OP_ORI, 6'd0, 1, E_DEC);
        step("ori_exec",   1, OP_ORI, 6'd0, 1, E_ORI);
        step("ori_wb",     1, OP_ORI, 6'd0, 1, E_WB_RT);

        step("beq_fetch",  1, OP_BEQ, 6'd0, 1, E_FETCH_R);
        step("beq_decode", 1, OP_BEQ, 6'd0, 1, E_DEC);
        step("beq_exec",   1, OP_BEQ, 6'd0, 1, E_BRANCH);

        step("j_fetch",  1, OP_J, 6'd0, 1, E_FETCH_R);
        step("j_decode", 1, OP_J, 6'd0, 1, E_DEC);
        step("j_exec",   1, OP_J, 6'd0, 1, E_JUMP);

        step("jal_fetch",  1, OP_JAL, 6'd0, 1, E_FETCH_R);
        step("jal_decode", 1, OP_JAL, 6'd0, 1, E_DEC);
        step("jal_exec",   1, OP_JAL, 6'd0, 1, E_JAL);

        step("jr_fetch",  1, OP_RTYPE, FN_JR, 1, E_FETCH_R);
        step("jr_decode", 1, OP_RTYPE, FN_JR, 1, E_DEC);
        step("jr_exec",   1, OP_RTYPE, FN_JR, 1, E_JR);

        step("ill_fetch",  1, 6'b111111, 6'd0, 1, E_FETCH_R);
        step("ill_decode", 1, 6'b111111, 6'd0, 1, E_DEC_ILL);

        step("swto_fetch",  1, OP_SW, 6'd0, 1, E_FETCH_R);
        step("swto_decode", 1, OP_SW, 6'd0, 1, E_DEC);
        step("swto_memadr", 1, OP_SW, 6'd0, 1, E_MADR);
        for (int i = 0; i < 16; i++) step("swto_wait", 1, OP_SW, 6'd0, 0, E_MWR);
        step("swto_timeout", 1, OP_SW, 6'd0, 0, E_MWR_TO);
        for (int i = 0; i < 3; i++) step("swto_fetch_wait", 1, OP_SW, 6'd0, 0, E_FETCH_W);

        step("swlim_fetch",  1, OP_SW, 6'd0, 1, E_FETCH_R);
        step("swlim_decode", 1, OP_SW, 6'd0, 1, E_DEC);
        step("swlim_memadr", 1, OP_SW, 6'd0, 1, E_MADR);
        for (int i = 0; i < 16; i++) step("swlim_wait", 1, OP_SW, 6'd0, 0, E_MWR);
        step("swlim_ready_at_limit", 1, OP_SW, 6'd0, 1, E_MWR);

        step("rst_addi_fetch",  1, OP_ADDI, 6'd0, 1, E_FETCH_R);
        step("rst_addi_decode", 1, OP_ADDI, 6'd0, 1, E_DEC);
        step("rst_addi_exec",   1, OP_ADDI, 6'd0, 1, E_ADDI);
        step("rst_in_aluwb",    0, OP_ADDI, 6'd0, 1, E_RST);
        step("rst_after",       1, OP_ADDI, 6'd0, 1, E_RST);
        step("rst_fetch",       1, OP_ADDI, 6'd0, 1, E_FETCH_R);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
